// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic array lock arbiter: channel FSM encoding
// and the round-robin pick used by every arbitration channel.
package sys_array_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Widest request vector the pick function accepts; channels zero-extend into it.
    localparam int MAX_THREADS = 32;

    // First asserted request at or after ptr, searching modulo n.
    function automatic int unsigned rr_pick(
        input logic [MAX_THREADS-1:0] req,
        input int unsigned            n,
        input int unsigned            ptr
    );
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_THREADS; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/sys_array_lock_arbiter_lock_channel.sv
// One arbitration channel: round-robin grant, address latch, lock hold until
// finished, and a watchdog that forces release of a stuck lock.
module lock_channel
    import sys_array_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int NTHREADS = 2,
    parameter int TIMEOUT  = 4096,
    parameter int NADDRS   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NTHREADS-1:0]        lock_req,
    input  logic [NADDRS*BITWIDTH-1:0] addr_in [NTHREADS],
    output logic [NTHREADS-1:0]        lock_res,
    output logic                       start,
    output logic [NADDRS*BITWIDTH-1:0] addr,
    input  logic                       finished,
    output logic                       timeout_err
);

    localparam int PTR_W = $clog2(NTHREADS);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t                  state_reg;
    logic [PTR_W-1:0]            rr_ptr_reg;
    logic [PTR_W-1:0]            grantee_reg;
    logic [CNT_W-1:0]            wd_cnt_reg;
    logic [NTHREADS-1:0]         lock_res_reg;
    logic                        start_reg;
    logic [NADDRS*BITWIDTH-1:0]  addr_reg;
    logic                        err_reg;

    logic [PTR_W-1:0]            pick_idx;
    logic [PTR_W-1:0]            ptr_next;

    always_comb begin
        pick_idx = PTR_W'(rr_pick(MAX_THREADS'(lock_req), NTHREADS, int'(rr_ptr_reg)));
        ptr_next = (grantee_reg == PTR_W'(NTHREADS - 1)) ? '0 : grantee_reg + PTR_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ARB_IDLE;
            rr_ptr_reg   <= '0;
            grantee_reg  <= '0;
            wd_cnt_reg   <= '0;
            lock_res_reg <= '0;
            start_reg    <= 1'b0;
            addr_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (|lock_req) begin
                        grantee_reg  <= pick_idx;
                        addr_reg     <= addr_in[pick_idx];
                        lock_res_reg <= NTHREADS'(1) << pick_idx;
                        start_reg    <= 1'b1;
                        wd_cnt_reg   <= '0;
                        state_reg    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // finished takes priority over an expiring watchdog
                    if (finished || wd_cnt_reg == CNT_LAST) begin
                        lock_res_reg <= '0;
                        rr_ptr_reg   <= ptr_next;
                        state_reg    <= ARB_RELEASE;
                        if (!finished) begin
                            err_reg <= 1'b1;
                        end
                    end else if (wd_cnt_reg != CNT_MAX) begin
                        wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
                    end
                end
                ARB_RELEASE: begin
                    state_reg <= ARB_IDLE;
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign lock_res    = lock_res_reg;
    assign start       = start_reg;
    assign addr        = addr_reg;
    assign timeout_err = err_reg;

endmodule

// File: rtl/sys_array_lock_arbiter.sv
// Arbitrates the systolic array's COMP (A/D/C) and LOAD (B) channels between
// hardware threads; the two channels run fully independently.
module sys_array_lock_arbiter
    import sys_array_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int NTHREADS = 2,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NTHREADS-1:0] comp_lock_req,
    input  logic [BITWIDTH-1:0] A_addr_in [NTHREADS],
    input  logic [BITWIDTH-1:0] D_addr_in [NTHREADS],
    input  logic [BITWIDTH-1:0] C_addr_in [NTHREADS],
    output logic [NTHREADS-1:0] comp_lock_res,
    output logic                comp_start,
    output logic [BITWIDTH-1:0] A_addr,
    output logic [BITWIDTH-1:0] D_addr,
    output logic [BITWIDTH-1:0] C_addr,
    input  logic                comp_finished,
    input  logic [NTHREADS-1:0] load_lock_req,
    input  logic [BITWIDTH-1:0] B_addr_in [NTHREADS],
    output logic [NTHREADS-1:0] load_lock_res,
    output logic                load_start,
    output logic [BITWIDTH-1:0] B_addr,
    input  logic                load_finished,
    output logic                comp_timeout_err,
    output logic                load_timeout_err
);

    logic [3*BITWIDTH-1:0] comp_addr_in [NTHREADS];
    logic [BITWIDTH-1:0]   load_addr_in [NTHREADS];
    logic [3*BITWIDTH-1:0] comp_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NTHREADS; gi++) begin : g_pack
            assign comp_addr_in[gi] = {A_addr_in[gi], D_addr_in[gi], C_addr_in[gi]};
            assign load_addr_in[gi] = B_addr_in[gi];
        end
    endgenerate

    lock_channel #(
        .BITWIDTH (BITWIDTH),
        .NTHREADS (NTHREADS),
        .TIMEOUT  (TIMEOUT),
        .NADDRS   (3)
    ) u_comp (
        .clock       (clock),
        .reset       (reset),
        .lock_req    (comp_lock_req),
        .addr_in     (comp_addr_in),
        .lock_res    (comp_lock_res),
        .start       (comp_start),
        .addr        (comp_addr),
        .finished    (comp_finished),
        .timeout_err (comp_timeout_err)
    );

    assign {A_addr, D_addr, C_addr} = comp_addr;

    lock_channel #(
        .BITWIDTH (BITWIDTH),
        .NTHREADS (NTHREADS),
        .TIMEOUT  (TIMEOUT),
        .NADDRS   (1)
    ) u_load (
        .clock       (clock),
        .reset       (reset),
        .lock_req    (load_lock_req),
        .addr_in     (load_addr_in),
        .lock_res    (load_lock_res),
        .start       (load_start),
        .addr        (B_addr),
        .finished    (load_finished),
        .timeout_err (load_timeout_err)
    );

endmodule

// File: tb/tb_sys_array_lock_arbiter.sv
// Directed bench for sys_array_lock_arbiter: grant timing, round-robin order,
// channel independence, watchdog release and asynchronous reset.
module tb_sys_array_lock_arbiter;

    localparam int BW = 16;
    localparam int NT = 2;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NT-1:0] comp_lock_req = '0;
    logic [BW-1:0] A_addr_in [NT];
    logic [BW-1:0] D_addr_in [NT];
    logic [BW-1:0] C_addr_in [NT];
    logic [NT-1:0] comp_lock_res;
    logic          comp_start;
    logic [BW-1:0] A_addr, D_addr, C_addr;
    logic          comp_finished = 1'b0;
    logic [NT-1:0] load_lock_req = '0;
    logic [BW-1:0] B_addr_in [NT];
    logic [NT-1:0] load_lock_res;
    logic          load_start;
    logic [BW-1:0] B_addr;
    logic          load_finished = 1'b0;
    logic          comp_timeout_err, load_timeout_err;

    int errors = 0;
    int checks = 0;

    sys_array_lock_arbiter #(.BITWIDTH(BW), .NTHREADS(NT), .TIMEOUT(TO)) dut (
        .clock            (clock),
        .reset            (reset),
        .comp_lock_req    (comp_lock_req),
        .A_addr_in        (A_addr_in),
        .D_addr_in        (D_addr_in),
        .C_addr_in        (C_addr_in),
        .comp_lock_res    (comp_lock_res),
        .comp_start       (comp_start),
        .A_addr           (A_addr),
        .D_addr           (D_addr),
        .C_addr           (C_addr),
        .comp_finished    (comp_finished),
        .load_lock_req    (load_lock_req),
        .B_addr_in        (B_addr_in),
        .load_lock_res    (load_lock_res),
        .load_start       (load_start),
        .B_addr           (B_addr),
        .load_finished    (load_finished),
        .comp_timeout_err (comp_timeout_err),
        .load_timeout_err (load_timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NT; i++) begin
            A_addr_in[i] = '0; D_addr_in[i] = '0; C_addr_in[i] = '0; B_addr_in[i] = '0;
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({comp_lock_res, load_lock_res, comp_start, load_start, comp_timeout_err, load_timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {comp_lock_res, load_lock_res, comp_start, load_start, comp_timeout_err, load_timeout_err});
        end
        checks++;
        if ({A_addr, D_addr, C_addr, B_addr} !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h required 0", {A_addr, D_addr, C_addr, B_addr});
        end
        reset = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_single_comp();
        A_addr_in[0] = 16'h0010; D_addr_in[0] = 16'h0020; C_addr_in[0] = 16'h0030;
        comp_lock_req = 2'b01;
        tick();
        checks++;
        if (comp_lock_res !== 2'b01 || comp_start !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got res=%b start=%b required res=01 start=1", comp_lock_res, comp_start);
        end
        checks++;
        if ({A_addr, D_addr, C_addr} !== {16'h0010, 16'h0020, 16'h0030}) begin
            errors++;
            $display("FAIL single_addr: got %h/%h/%h required 0010/0020/0030", A_addr, D_addr, C_addr);
        end
        comp_lock_req = 2'b00;
        tick();
        checks++;
        if (comp_start !== 1'b0 || comp_lock_res !== 2'b01) begin
            errors++;
            $display("FAIL single_hold: got res=%b start=%b required res=01 start=0", comp_lock_res, comp_start);
        end
        tick(); tick(); tick();
        comp_finished = 1'b1;
        tick();
        comp_finished = 1'b0;
        checks++;
        if (comp_lock_res !== 2'b00) begin
            errors++;
            $display("FAIL single_release: got res=%b required 00", comp_lock_res);
        end
        checks++;
        if (A_addr !== 16'h0010) begin
            errors++;
            $display("FAIL single_addr_hold: got %h required 0010", A_addr);
        end
        tick();
        $display("single_comp: grant to thread 0, released after finished");
    endtask

    task automatic test_round_robin();
        logic [NT-1:0] exp_res;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        A_addr_in[0] = 16'h0100; A_addr_in[1] = 16'h0111;
        comp_lock_req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_res = (g % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++;
            if (comp_lock_res !== exp_res || comp_start !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d: got res=%b start=%b required res=%b start=1", g, comp_lock_res, comp_start, exp_res);
            end
            checks++;
            if (A_addr !== ((g % 2 == 0) ? 16'h0100 : 16'h0111)) begin
                errors++;
                $display("FAIL rr_addr%0d: got %h required %h", g, A_addr, (g % 2 == 0) ? 16'h0100 : 16'h0111);
            end
            tick(); tick();
            comp_finished = 1'b1;
            tick();
            comp_finished = 1'b0;
            checks++;
            if (comp_lock_res !== 2'b00) begin
                errors++;
                $display("FAIL rr_release%0d: got res=%b required 00", g, comp_lock_res);
            end
            if (g == 3) comp_lock_req = 2'b00;
            tick();
            checks++;
            if (comp_lock_res !== 2'b00 || comp_start !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap%0d: got res=%b start=%b required 00/0", g, comp_lock_res, comp_start);
            end
            $display("round_robin: grant %0d to res=%b", g, exp_res);
        end
    endtask

    task automatic test_independent();
        A_addr_in[0] = 16'h0001; D_addr_in[0] = 16'h0002; C_addr_in[0] = 16'h0003;
        comp_lock_req = 2'b01;
        tick();
        checks++;
        if (comp_lock_res !== 2'b01) begin
            errors++;
            $display("FAIL indep_comp_grant: got res=%b required 01", comp_lock_res);
        end
        comp_lock_req = 2'b00;
        B_addr_in[0] = 16'h0099; B_addr_in[1] = 16'h0040;
        load_lock_req = 2'b10;
        tick();
        checks++;
        if (load_lock_res !== 2'b10 || load_start !== 1'b1 || B_addr !== 16'h0040) begin
            errors++;
            $display("FAIL indep_load_grant: got res=%b start=%b B=%h required 10/1/0040", load_lock_res, load_start, B_addr);
        end
        checks++;
        if (comp_lock_res !== 2'b01 || comp_start !== 1'b0) begin
            errors++;
            $display("FAIL indep_comp_held: got res=%b start=%b required 01/0", comp_lock_res, comp_start);
        end
        load_finished = 1'b1;
        tick();
        load_finished = 1'b0;
        checks++;
        if (load_lock_res !== 2'b00 || comp_lock_res !== 2'b01) begin
            errors++;
            $display("FAIL indep_load_release: got load=%b comp=%b required 00/01", load_lock_res, comp_lock_res);
        end
        load_lock_req = 2'b00;
        comp_finished = 1'b1;
        tick();
        comp_finished = 1'b0;
        checks++;
        if (comp_lock_res !== 2'b00 || load_lock_res !== 2'b00) begin
            errors++;
            $display("FAIL indep_comp_release: got comp=%b load=%b required 00/00", comp_lock_res, load_lock_res);
        end
        tick();
        $display("independent: comp thread 0 and load thread 1 granted concurrently");
    endtask

    task automatic test_timeout();
        comp_lock_req = 2'b01;
        tick();
        checks++;
        if (comp_lock_res !== 2'b01) begin
            errors++;
            $display("FAIL to_grant: got res=%b required 01", comp_lock_res);
        end
        comp_lock_req = 2'b00;
        for (int i = 1; i < TO; i++) begin
            tick();
            checks++;
            if (comp_lock_res !== 2'b01 || comp_timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL to_hold%0d: got res=%b err=%b required 01/0", i, comp_lock_res, comp_timeout_err);
            end
        end
        tick();
        checks++;
        if (comp_lock_res !== 2'b00 || comp_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_release: got res=%b err=%b required 00/1", comp_lock_res, comp_timeout_err);
        end
        comp_finished = 1'b1;
        tick();
        comp_finished = 1'b0;
        checks++;
        if (comp_lock_res !== 2'b00 || comp_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: got res=%b err=%b required 00/1", comp_lock_res, comp_timeout_err);
        end
        tick();
        $display("timeout: forced release after %0d cycles", TO);
    endtask

    task automatic test_reset_mid_busy();
        A_addr_in[0] = 16'h0055; D_addr_in[0] = 16'h0066; C_addr_in[0] = 16'h0077;
        comp_lock_req = 2'b01;
        tick();
        checks++;
        if (comp_lock_res !== 2'b01) begin
            errors++;
            $display("FAIL rst_pre_grant: got res=%b required 01", comp_lock_res);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({comp_lock_res, comp_start, comp_timeout_err, A_addr, D_addr, C_addr} !== '0) begin
            errors++;
            $display("FAIL rst_async: got res=%b start=%b err=%b A=%h D=%h C=%h required all 0", comp_lock_res, comp_start, comp_timeout_err, A_addr, D_addr, C_addr);
        end
        comp_lock_req = 2'b00;
        comp_finished = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        comp_finished = 1'b0;
        checks++;
        if (comp_lock_res !== 2'b00 || comp_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_finish_ignored: got res=%b start=%b required 00/0", comp_lock_res, comp_start);
        end
        tick();
        checks++;
        if (comp_lock_res !== 2'b00 || comp_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_grant: got res=%b start=%b required 00/0", comp_lock_res, comp_start);
        end
        comp_lock_req = 2'b01;
        tick();
        checks++;
        if (comp_lock_res !== 2'b01 || comp_start !== 1'b1 || A_addr !== 16'h0055) begin
            errors++;
            $display("FAIL rst_fresh_grant: got res=%b start=%b A=%h required 01/1/0055", comp_lock_res, comp_start, A_addr);
        end
        comp_lock_req = 2'b00;
        comp_finished = 1'b1;
        tick();
        comp_finished = 1'b0;
        tick();
        $display("reset_mid_busy: outputs cleared, fresh request granted");
    endtask

    task automatic test_finish_at_timeout();
        comp_lock_req = 2'b01;
        tick();
        checks++;
        if (comp_lock_res !== 2'b01) begin
            errors++;
            $display("FAIL fat_grant: got res=%b required 01", comp_lock_res);
        end
        comp_lock_req = 2'b00;
        for (int i = 1; i < TO; i++) tick();
        comp_finished = 1'b1;
        tick();
        comp_finished = 1'b0;
        checks++;
        if (comp_lock_res !== 2'b00 || comp_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL fat_release: got res=%b err=%b required 00/0", comp_lock_res, comp_timeout_err);
        end
        tick();
        $display("finish_at_timeout: finished wins, no error flag");
    endtask

    initial begin
        test_reset();
        test_single_comp();
        test_round_robin();
        test_independent();
        test_timeout();
        test_reset_mid_busy();
        test_finish_at_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
